cache_mem_responder: RTL and testbench

Memory-side responder for the cache-to-memory request interface: it accepts refill reads and write-back or uncached writes from a cache. It serves them from an internal word-addressed memory array, returning read data as a fixed-latency burst of 32-bit beats. It sits in `model/vsrc` as the simulation counterpart of the cache's miss and write-back path. It turns the request size and offset back into a byte mask, the inverse of the cache's strobe-to-size conversion.

---
 rtl/cache_if_pkg.sv | 17 +
 rtl/size2strb.sv | 21 ++
 rtl/wstrb_mixer.sv | 16 +
 rtl/cache_mem_responder.sv | 184 ++++++++++++++++++
 tb/tb_cache_mem_responder.sv | 320 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cache_if_pkg.sv
// Shared encodings for the cache-to-memory request interface and the
// responder's state machine.
package cache_if_pkg;

  localparam logic [2:0] TYPE_BYTE = 3'b000;
  localparam logic [2:0] TYPE_HALF = 3'b001;
  localparam logic [2:0] TYPE_WORD = 3'b010;
  localparam logic [2:0] TYPE_LINE = 3'b100;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RD_WAIT   = 2'd1,
    RD_BEAT   = 2'd2,
    WR_COMMIT = 2'd3
  } state_e;

endpackage

// File: rtl/size2strb.sv
// Rebuilds a byte mask from a request size and the low address bits.
// This is the inverse of the cache's strobe-to-size conversion.
module size2strb
  import cache_if_pkg::*;
(
  input  logic [2:0] req_type,
  input  logic [1:0] off,
  output logic [3:0] strb
);

  always_comb begin
    strb = 4'b1111;
    case (req_type)
      TYPE_BYTE: strb = 4'b0001 << off;
      TYPE_HALF: strb = 4'b0011 << {off[1], 1'b0};
      TYPE_WORD: strb = 4'b1111;
      default:   strb = 4'b1111;
    endcase
  end

endmodule

// File: rtl/wstrb_mixer.sv
// Byte-lane merge: each strobed lane takes new data, the rest keep old data.
module wstrb_mixer (
  input  logic [31:0] old_data,
  input  logic [31:0] new_data,
  input  logic [3:0]  strb,
  output logic [31:0] mixed
);

  always_comb begin
    mixed = old_data;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) mixed[8*b +: 8] = new_data[8*b +: 8];
    end
  end

endmodule

// File: rtl/cache_mem_responder.sv
// Memory-side responder for cache refills and write-backs.  It serves them
// from a word array and returns reads as a fixed-latency burst of beats.
module cache_mem_responder
  import cache_if_pkg::*;
#(
  parameter int MEM_WORDS  = 4096,
  parameter int LINE_WORDS = 4,
  parameter int RD_LATENCY = 2
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      rd_req,
  input  logic [2:0]                rd_type,
  input  logic [31:0]               rd_addr,
  output logic                      rd_rdy,
  output logic                      ret_valid,
  output logic                      ret_last,
  output logic [31:0]               ret_data,
  input  logic                      wr_req,
  input  logic [2:0]                wr_type,
  input  logic [31:0]               wr_addr,
  input  logic [3:0]                wr_wstrb,
  input  logic [32*LINE_WORDS-1:0]  wr_data,
  output logic                      wr_rdy
);

  localparam int AW = $clog2(MEM_WORDS);
  localparam int LB = $clog2(LINE_WORDS);
  localparam int CW = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
  localparam int BW = LB + 1;
  localparam logic [AW-1:0] LINE_MASK = AW'(LINE_WORDS - 1);
  localparam logic [CW-1:0] LAT_LOAD  = CW'(RD_LATENCY - 1);
  localparam logic [BW-1:0] LINE_LAST = BW'(LINE_WORDS - 1);

  // Handshake rule: a request transfers on a rising edge where its req and
  // rdy are both high; read beats carry no backpressure.
  state_e                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [AW-1:0]           idx_q, idx_d;
  logic [BW-1:0]           left_q, left_d;
  logic                    ret_last_q, ret_last_d;
  logic [31:0]             ret_data_q, ret_data_d;
  logic                    wline_q, wline_d;
  logic [AW-1:0]           widx_q, widx_d;
  logic [3:0]              wmask_q, wmask_d;
  logic [32*LINE_WORDS-1:0] wdata_q, wdata_d;
  logic [31:0]             mem_q [MEM_WORDS];

  logic          idle, rd_fire, wr_fire, emit;
  logic [AW-1:0] rd_idx, wr_idx, emit_idx;
  logic [BW-1:0] emit_left;
  logic          rd_line, wr_line;
  logic [3:0]    size_strb;
  logic [31:0]   merged;
  logic          unused_addr_bits;

  // Upper address bits are dropped, so addresses wrap modulo the array.
  assign rd_idx  = rd_addr[AW+1:2];
  assign wr_idx  = wr_addr[AW+1:2];
  assign rd_line = (rd_type == TYPE_LINE);
  assign wr_line = (wr_type == TYPE_LINE);
  assign rd_fire = rd_req & rd_rdy;
  assign wr_fire = wr_req & wr_rdy;
  assign unused_addr_bits = ^{rd_addr[31:AW+2], rd_addr[1:0], wr_addr[31:AW+2]};

  size2strb u_size2strb (
    .req_type (wr_type),
    .off      (wr_addr[1:0]),
    .strb     (size_strb)
  );

  wstrb_mixer u_wstrb_mixer (
    .old_data (mem_q[widx_q]),
    .new_data (wdata_q[31:0]),
    .strb     (wmask_q),
    .mixed    (merged)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    left_d     = left_q;
    ret_last_d = ret_last_q;
    ret_data_d = ret_data_q;
    wline_d    = wline_q;
    widx_d     = widx_q;
    wmask_d    = wmask_q;
    wdata_d    = wdata_q;
    emit       = 1'b0;
    emit_idx   = idx_q;
    emit_left  = left_q;
    case (state_q)
      IDLE: begin
        if (wr_fire) begin
          wline_d = wr_line;
          widx_d  = wr_line ? (wr_idx & ~LINE_MASK) : wr_idx;
          wmask_d = wr_line ? 4'b1111 : (size_strb & wr_wstrb);
          wdata_d = wr_data;
          state_d = WR_COMMIT;
        end else if (rd_fire) begin
          emit_idx  = rd_line ? (rd_idx & ~LINE_MASK) : rd_idx;
          emit_left = rd_line ? LINE_LAST : '0;
          idx_d     = emit_idx;
          left_d    = emit_left;
          cnt_d     = LAT_LOAD;
          state_d   = RD_WAIT;
          if (cnt_d == '0) emit = 1'b1;
        end
      end
      RD_WAIT: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_d == '0) emit = 1'b1;
      end
      RD_BEAT: begin
        if (ret_last_q) state_d = IDLE;
        else            emit = 1'b1;
      end
      WR_COMMIT: state_d = IDLE;
      default:   state_d = IDLE;
    endcase
    // A beat is registered on the edge before the cycle it is presented in.
    if (emit) begin
      state_d    = RD_BEAT;
      ret_data_d = mem_q[emit_idx];
      ret_last_d = (emit_left == '0);
      idx_d      = emit_idx + AW'(1);
      left_d     = emit_left - BW'(1);
    end
  end

  always_comb begin
    idle      = (state_q == IDLE) & ~reset;
    wr_rdy    = idle;
    rd_rdy    = idle & ~wr_req;
    ret_valid = (state_q == RD_BEAT);
    ret_last  = ret_valid & ret_last_q;
    ret_data  = ret_data_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q      <= '0;
      idx_q      <= '0;
      left_q     <= '0;
      ret_last_q <= 1'b0;
      ret_data_q <= '0;
      wline_q    <= 1'b0;
      widx_q     <= '0;
      wmask_q    <= '0;
      wdata_q    <= '0;
    end else begin
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      left_q     <= left_d;
      ret_last_q <= ret_last_d;
      ret_data_q <= ret_data_d;
      wline_q    <= wline_d;
      widx_q     <= widx_d;
      wmask_q    <= wmask_d;
      wdata_q    <= wdata_d;
    end
  end

  // Array contents survive reset; a reset before this edge leaves the
  // state out of WR_COMMIT, which drops the pending write.
  always_ff @(posedge clock) begin
    if (state_q == WR_COMMIT) begin
      if (wline_q) begin
        for (int i = 0; i < LINE_WORDS; i++) begin
          mem_q[widx_q + AW'(i)] <= wdata_q[32*i +: 32];
        end
      end else begin
        mem_q[widx_q] <= merged;
      end
    end
  end

endmodule

// File: tb/tb_cache_mem_responder.sv
// Bench for cache_mem_responder: table-driven requests, a beat scoreboard
// with cycle-exact timing, and hand-written reset and arbitration sequences.
module tb_cache_mem_responder;
  import cache_if_pkg::*;

  localparam int MEM_WORDS  = 4096;
  localparam int LINE_WORDS = 4;
  localparam int RD_LAT     = 2;
  localparam int TO         = 50;
  localparam int NTAB       = 17;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         rd_req = 1'b0;
  logic [2:0]   rd_type = '0;
  logic [31:0]  rd_addr = '0;
  logic         rd_rdy;
  logic         ret_valid;
  logic         ret_last;
  logic [31:0]  ret_data;
  logic         wr_req = 1'b0;
  logic [2:0]   wr_type = '0;
  logic [31:0]  wr_addr = '0;
  logic [3:0]   wr_wstrb = '0;
  logic [127:0] wr_data = '0;
  logic         wr_rdy;

  cache_mem_responder #(
    .MEM_WORDS  (MEM_WORDS),
    .LINE_WORDS (LINE_WORDS),
    .RD_LATENCY (RD_LAT)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .rd_req    (rd_req),
    .rd_type   (rd_type),
    .rd_addr   (rd_addr),
    .rd_rdy    (rd_rdy),
    .ret_valid (ret_valid),
    .ret_last  (ret_last),
    .ret_data  (ret_data),
    .wr_req    (wr_req),
    .wr_type   (wr_type),
    .wr_addr   (wr_addr),
    .wr_wstrb  (wr_wstrb),
    .wr_data   (wr_data),
    .wr_rdy    (wr_rdy)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_pass   = 0;
  int beats_seen = 0;
  logic [64:0] exp_q[$];   // {cycle[31:0], last, data[31:0]}
  logic [31:0] model_mem [MEM_WORDS];

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endfunction

  function automatic logic [3:0] exp_mask(input logic [2:0] t, input logic [1:0] off);
    logic [3:0] m;
    case (t)
      TYPE_BYTE: case (off)
                   2'd0: m = 4'b0001;
                   2'd1: m = 4'b0010;
                   2'd2: m = 4'b0100;
                   default: m = 4'b1000;
                 endcase
      TYPE_HALF: m = off[1] ? 4'b1100 : 4'b0011;
      default:   m = 4'b1111;
    endcase
    return m;
  endfunction

  function automatic void model_write(input logic [2:0] t, input logic [31:0] a,
                                      input logic [3:0] s, input logic [127:0] d);
    logic [3:0] m;
    int base;
    if (t == TYPE_LINE) begin
      base = int'(a[13:4]) * 4;
      for (int k = 0; k < 4; k++) model_mem[base + k] = d[32*k +: 32];
    end else begin
      m = exp_mask(t, a[1:0]) & s;
      for (int b = 0; b < 4; b++)
        if (m[b]) model_mem[a[13:2]][8*b +: 8] = d[8*b +: 8];
    end
  endfunction

  function automatic void exp_read(input logic [2:0] t, input logic [31:0] a,
                                   output logic [127:0] w, output int nb);
    int base;
    w = '0;
    if (t == TYPE_LINE) begin
      base = int'(a[13:4]) * 4;
      for (int k = 0; k < 4; k++) w[32*k +: 32] = model_mem[base + k];
      nb = 4;
    end else begin
      w[31:0] = model_mem[a[13:2]];
      nb = 1;
    end
  endfunction

  // ---------------- driver tasks ----------------
  task automatic do_write(input logic [2:0] t, input logic [31:0] a,
                          input logic [3:0] s, input logic [127:0] d);
    int n = 0;
    @(negedge clock);
    wr_req = 1'b1; wr_type = t; wr_addr = a; wr_wstrb = s; wr_data = d;
    #1;
    while (!wr_rdy && n < TO) begin @(negedge clock); #1; n++; end
    if (!wr_rdy) begin
      chk("wr_accept_timeout", 0, 1);
      wr_req = 1'b0;
      return;
    end
    @(posedge clock); #1;
    wr_req = 1'b0;
    model_write(t, a, s, d);
  endtask

  task automatic do_read(input logic [2:0] t, input logic [31:0] a,
                         input logic [127:0] w, input int nb);
    int n = 0;
    int h;
    @(negedge clock);
    rd_req = 1'b1; rd_type = t; rd_addr = a;
    #1;
    while (!rd_rdy && n < TO) begin @(negedge clock); #1; n++; end
    if (!rd_rdy) begin
      chk("rd_accept_timeout", 0, 1);
      rd_req = 1'b0;
      return;
    end
    @(posedge clock); #1;
    h = cyc;
    rd_req = 1'b0;
    for (int k = 0; k < nb; k++)
      exp_q.push_back({32'(h - 1 + RD_LAT + k), (k == nb - 1), w[32*k +: 32]});
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < TO) begin @(negedge clock); #2; n++; end
    if (exp_q.size() != 0) begin
      chk("drain_timeout", 64'(exp_q.size()), 0);
      exp_q.delete();
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [64:0] e;
  always @(negedge clock) begin
    if (!reset && ret_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_beat", {32'(cyc), ret_data}, 0);
      end else begin
        e = exp_q.pop_front();
        chk("beat_data",  ret_data, e[31:0]);
        chk("beat_last",  ret_last, e[32]);
        chk("beat_cycle", cyc, e[64:33]);
        beats_seen++;
      end
    end
  end

  // ---------------- stimulus ----------------
  typedef struct {
    bit           is_wr;
    logic [2:0]   typ;
    logic [31:0]  addr;
    logic [3:0]   strb;
    logic [127:0] data;
    logic [127:0] exp;
    int           nb;
  } vec_t;

  vec_t tab [NTAB];
  logic [2:0] wtypes [4] = '{TYPE_BYTE, TYPE_HALF, TYPE_WORD, TYPE_LINE};
  logic [2:0] rtypes [3] = '{TYPE_BYTE, TYPE_WORD, TYPE_LINE};

  initial begin
    logic [127:0] w;
    int nb, base, n, w_cyc, h;
    logic [31:0] a;
    logic [2:0] t;

    tab[0]  = '{1, TYPE_LINE, 32'h100, 4'hF,
                {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111}, '0, 0};
    tab[1]  = '{0, TYPE_LINE, 32'h108, 4'h0, '0,
                {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111}, 4};
    tab[2]  = '{1, TYPE_BYTE, 32'h101, 4'hF, 128'h0000AB00, '0, 0};
    tab[3]  = '{0, TYPE_WORD, 32'h100, 4'h0, '0, 128'h1111AB11, 1};
    tab[4]  = '{1, TYPE_HALF, 32'h102, 4'b0100, 128'hBEEF0000, '0, 0};
    tab[5]  = '{0, TYPE_WORD, 32'h100, 4'h0, '0, 128'h11EFAB11, 1};
    tab[6]  = '{1, TYPE_HALF, 32'h101, 4'b1100, 128'hFFFFFFFF, '0, 0};
    tab[7]  = '{0, TYPE_BYTE, 32'h103, 4'h0, '0, 128'h11EFAB11, 1};
    tab[8]  = '{1, TYPE_WORD, 32'h100, 4'hF, 128'hCAFEF00D, '0, 0};
    tab[9]  = '{1, TYPE_WORD, 32'h100 + 4*MEM_WORDS, 4'hF, 128'h0BADBEEF, '0, 0};
    tab[10] = '{0, TYPE_WORD, 32'h100, 4'h0, '0, 128'h0BADBEEF, 1};
    tab[11] = '{0, TYPE_WORD, 32'h100 + 4*MEM_WORDS, 4'h0, '0, 128'h0BADBEEF, 1};
    tab[12] = '{1, TYPE_BYTE, 32'h10F, 4'b1000, 128'h5A000000, '0, 0};
    tab[13] = '{0, TYPE_LINE, 32'h10C, 4'h0, '0,
                {32'h5A444444, 32'h33333333, 32'h22222222, 32'h0BADBEEF}, 4};
    tab[14] = '{1, TYPE_LINE, 32'h208, 4'h0,
                {32'hD3D3D3D3, 32'hC2C2C2C2, 32'hB1B1B1B1, 32'hA0A0A0A0}, '0, 0};
    tab[15] = '{0, TYPE_LINE, 32'h204, 4'h0, '0,
                {32'hD3D3D3D3, 32'hC2C2C2C2, 32'hB1B1B1B1, 32'hA0A0A0A0}, 4};
    tab[16] = '{0, TYPE_HALF, 32'h20A, 4'h0, '0, 128'hC2C2C2C2, 1};

    // reset state
    @(negedge clock); #1;
    chk("rst_rd_rdy",    rd_rdy, 0);
    chk("rst_wr_rdy",    wr_rdy, 0);
    chk("rst_ret_valid", ret_valid, 0);
    chk("rst_ret_last",  ret_last, 0);
    chk("rst_ret_data",  ret_data, 0);
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("post_rst_rd_rdy", rd_rdy, 1);
    chk("post_rst_wr_rdy", wr_rdy, 1);

    // table-driven vectors
    for (int i = 0; i < NTAB; i++) begin
      if (tab[i].is_wr) do_write(tab[i].typ, tab[i].addr, tab[i].strb, tab[i].data);
      else              do_read(tab[i].typ, tab[i].addr, tab[i].exp, tab[i].nb);
    end
    wait_drain();

    // rd_rdy low through the last beat, high the cycle after
    exp_read(TYPE_LINE, 32'h200, w, nb);
    base = beats_seen;
    do_read(TYPE_LINE, 32'h200, w, nb);
    n = 0;
    while (beats_seen < base + 4 && n < TO) begin @(negedge clock); #2; n++; end
    chk("rd_rdy_during_last_beat", rd_rdy, 0);
    @(negedge clock); #1;
    chk("rd_rdy_after_last_beat", rd_rdy, 1);

    // simultaneous read and write: write wins, read follows at T+2
    @(negedge clock);
    wr_req = 1'b1; wr_type = TYPE_WORD; wr_addr = 32'h300; wr_wstrb = 4'hF;
    wr_data = 128'h5EED1234;
    rd_req = 1'b1; rd_type = TYPE_WORD; rd_addr = 32'h300;
    #1;
    chk("both_wr_rdy", wr_rdy, 1);
    chk("both_rd_rdy", rd_rdy, 0);
    @(posedge clock); #1;
    w_cyc = cyc;
    wr_req = 1'b0;
    model_write(TYPE_WORD, 32'h300, 4'hF, 128'h5EED1234);
    @(negedge clock); #1;
    chk("commit_rd_rdy", rd_rdy, 0);
    @(negedge clock); #1;
    chk("after_commit_rd_rdy", rd_rdy, 1);
    @(posedge clock); #1;
    h = cyc;
    rd_req = 1'b0;
    chk("read_after_write_cycle", h, w_cyc + 2);
    exp_q.push_back({32'(h - 1 + RD_LAT), 1'b1, 32'h5EED1234});
    wait_drain();

    // reset during beat 2 of a line read
    exp_read(TYPE_LINE, 32'h100, w, nb);
    base = beats_seen;
    do_read(TYPE_LINE, 32'h100, w, nb);
    n = 0;
    while (beats_seen < base + 2 && n < TO) begin @(negedge clock); #2; n++; end
    chk("beats_before_reset", beats_seen - base, 2);
    reset = 1'b1;
    #1;
    chk("midburst_ret_valid", ret_valid, 0);
    chk("midburst_ret_last",  ret_last, 0);
    chk("midburst_rd_rdy",    rd_rdy, 0);
    chk("midburst_wr_rdy",    wr_rdy, 0);
    exp_q.delete();
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("rerst_rd_rdy", rd_rdy, 1);
    chk("rerst_wr_rdy", wr_rdy, 1);
    repeat (6) @(negedge clock);
    exp_read(TYPE_LINE, 32'h104, w, nb);
    do_read(TYPE_LINE, 32'h104, w, nb);
    wait_drain();

    // random traffic over a small window
    for (int k = 0; k < 4; k++)
      do_write(TYPE_LINE, 32'h800 + 32'(16 * k), 4'h0,
               {$urandom, $urandom, $urandom, $urandom});
    for (int r = 0; r < 30; r++) begin
      a = 32'h800 + 32'($urandom_range(0, 63));
      if ($urandom_range(0, 1) == 1) begin
        t = wtypes[$urandom_range(0, 3)];
        do_write(t, a, 4'($urandom_range(0, 15)), {$urandom, $urandom, $urandom, $urandom});
      end else begin
        t = rtypes[$urandom_range(0, 2)];
        exp_read(t, a, w, nb);
        do_read(t, a, w, nb);
      end
    end
    wait_drain();
    repeat (4) @(negedge clock);
    chk("queue_empty_at_end", 64'(exp_q.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
